tm1637_rx: RTL

- Target-side (display-end) receiver for the two-wire TM1637 bus. Samples open-drain SCL/SDA driven by the bus master, detects START/STOP, shifts in bytes LSB-first and drives the ACK slot.
- Presents each received byte with a one-cycle valid strobe.
- Used as an on-chip display/peripheral model and as the loopback target for the existing bus-master block.

---
 rtl/tm1637_rx_if.sv | 29 ++
 rtl/tm1637_rx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/tm1637_rx_if.sv
// tm1637_rx_if: bus pads, ack control and byte output of the receiver.
// slave = receiver side, master = bus/host side.
interface tm1637_rx_if #(
  parameter int IDX_W = 4
);
  logic             scl_in;
  logic             sda_in;
  logic             ack_en;
  logic             sda_en;
  logic [7:0]       data_out;
  logic             data_valid;
  logic [IDX_W-1:0] byte_index;
  logic             start_det;
  logic             stop_det;
  logic             frame_err;
  logic             busy;

  modport slave (
    input  scl_in, sda_in, ack_en,
    output sda_en, data_out, data_valid, byte_index,
    output start_det, stop_det, frame_err, busy
  );

  modport master (
    output scl_in, sda_in, ack_en,
    input  sda_en, data_out, data_valid, byte_index,
    input  start_det, stop_det, frame_err, busy
  );
endinterface

// File: rtl/tm1637_rx.sv
// tm1637_rx: TM1637 target receiver, LSB-first bytes, drives ACK slot.
// Ports: clk, rst_n, bus (scl/sda in, sda_en out, byte + event pulses).
module tm1637_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int IDX_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  tm1637_rx_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE, BITS, ACK_DRIVE, ACK_HOLD
  } state_t;

  logic [SYNC_STAGES-1:0] scl_s, sda_s;
  logic scl_h, sda_h;
  logic scl_v, sda_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s <= '1;
      sda_s <= '1;
      scl_h <= 1'b1;
      sda_h <= 1'b1;
    end else begin
      scl_s <= {scl_s[SYNC_STAGES-2:0], bus.scl_in};
      sda_s <= {sda_s[SYNC_STAGES-2:0], bus.sda_in};
      scl_h <= scl_v;
      sda_h <= sda_v;
    end
  end

  assign scl_v = scl_s[SYNC_STAGES-1];
  assign sda_v = sda_s[SYNC_STAGES-1];

  logic scl_rise, scl_fall, scl_same;
  logic start, stop;

  assign scl_rise = scl_v & ~scl_h;
  assign scl_fall = ~scl_v & scl_h;
  assign scl_same = ~(scl_v ^ scl_h);
  assign start = scl_v & scl_same & sda_h & ~sda_v;
  assign stop  = scl_v & scl_same & ~sda_h & sda_v;

  state_t           state, state_n;
  logic [2:0]       cnt, cnt_n;
  // pend: a rise was taken for the current bit; the count
  // only advances on its matching fall, so the SCL rise of
  // a STOP/repeated START is never counted as a data bit.
  logic             pend, pend_n;
  logic [7:0]       sh, sh_n;
  logic [IDX_W-1:0] bc, bc_n;
  logic [7:0]       dout, dout_n;
  logic             dv, dv_n;
  logic [IDX_W-1:0] bi, bi_n;
  logic             st, st_n;
  logic             sp, sp_n;
  logic             fe, fe_n;
  logic             bsy, bsy_n;
  logic             sen, sen_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= 1'b0;
      sh    <= '0;
      bc    <= '0;
      dout  <= '0;
      dv    <= 1'b0;
      bi    <= '0;
      st    <= 1'b0;
      sp    <= 1'b0;
      fe    <= 1'b0;
      bsy   <= 1'b0;
      sen   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pend  <= pend_n;
      sh    <= sh_n;
      bc    <= bc_n;
      dout  <= dout_n;
      dv    <= dv_n;
      bi    <= bi_n;
      st    <= st_n;
      sp    <= sp_n;
      fe    <= fe_n;
      bsy   <= bsy_n;
      sen   <= sen_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    sh_n    = sh;
    bc_n    = bc;
    dout_n  = dout;
    dv_n    = 1'b0;
    bi_n    = bi;
    st_n    = 1'b0;
    sp_n    = 1'b0;
    fe_n    = 1'b0;
    bsy_n   = bsy;
    sen_n   = sen;
    if (start) begin
      st_n    = 1'b1;
      fe_n    = (cnt != 3'd0);
      cnt_n   = '0;
      pend_n  = 1'b0;
      sh_n    = '0;
      bc_n    = '0;
      sen_n   = 1'b0;
      bsy_n   = 1'b1;
      state_n = BITS;
    end else if (stop && state != IDLE) begin
      sp_n    = 1'b1;
      fe_n    = (cnt != 3'd0);
      cnt_n   = '0;
      pend_n  = 1'b0;
      sen_n   = 1'b0;
      bsy_n   = 1'b0;
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: ;
        BITS: begin
          if (scl_rise) begin
            sh_n[cnt] = sda_v;
            pend_n    = 1'b1;
            if (cnt == 3'd7) begin
              dout_n  = {sda_v, sh[6:0]};
              dv_n    = 1'b1;
              bi_n    = bc;
              cnt_n   = '0;
              pend_n  = 1'b0;
              state_n = ACK_DRIVE;
            end
          end else if (scl_fall && pend) begin
            cnt_n  = cnt + 3'd1;
            pend_n = 1'b0;
          end
        end
        ACK_DRIVE: begin
          if (scl_fall) begin
            sen_n   = bus.ack_en;
            state_n = ACK_HOLD;
          end
        end
        ACK_HOLD: begin
          if (scl_fall) begin
            sen_n   = 1'b0;
            cnt_n   = '0;
            if (bc != '1) bc_n = bc + IDX_W'(1);
            state_n = BITS;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.sda_en     = sen;
  assign bus.data_out   = dout;
  assign bus.data_valid = dv;
  assign bus.byte_index = bi;
  assign bus.start_det  = st;
  assign bus.stop_det   = sp;
  assign bus.frame_err  = fe;
  assign bus.busy       = bsy;

endmodule
